decode_stream: RTL and testbench

DECODE_STREAM -- requirements
Module: decode_stream

---
 rtl/decode_stream_pkg.sv | 13 +
 rtl/decode_stream_decode.sv | 24 ++
 rtl/decode_stream.sv | 131 +++++++++++++
 tb/tb_decode_stream.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/decode_stream_pkg.sv
// decode_stream_pkg: shared definitions for the decode_stream block.
//   IDLE / ACCUM : burst accumulator FSM state encodings
//   cw()         : count width for a given one-hot width, $clog2(width) + 1
package decode_stream_pkg;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    function automatic int unsigned cw(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/decode_stream_decode.sv
// decode_stream_decode: combinational binary-to-one-hot decoder.
// Ports:
//   A  in  [m-1:0]     binary index
//   Z  out [width-1:0] one-hot decode of A, all zero when A >= width
module decode_stream_decode
    import decode_stream_pkg::*;
#(
    parameter  int unsigned width = 8,
    localparam int unsigned m     = $clog2(width)
) (
    input  logic [m-1:0]     A,
    output logic [width-1:0] Z
);

    always_comb begin
        Z = '0;
        for (int unsigned i = 0; i < width; i++) begin
            if (A == m'(i)) begin
                Z[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decode_stream.sv
// decode_stream: accumulates a burst of binary indices into one-hot OR, beat count
// (saturating), duplicate flag and optional range-error flag, and emits one result
// per burst through a valid/ready output register.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      input handshake; A = beat index, in_last = final beat
//   out_valid/out_ready    output handshake
//   Z, Z_cnt, Z_dup, Z_err burst result
// Build option: define DECODE_STREAM_RANGE_CHECK_EN to flag beats with A >= width
// on Z_err; otherwise Z_err is constant 0.
module decode_stream
    import decode_stream_pkg::*;
#(
    parameter  int unsigned width = 8,
    localparam int unsigned m     = $clog2(width),
    localparam int unsigned cwid  = cw(width)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [m-1:0]     A,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] Z,
    output logic [cwid-1:0]  Z_cnt,
    output logic             Z_dup,
    output logic             Z_err
);

    localparam logic [cwid-1:0] cnt_max = '1;

    logic [0:0]       state_q;
    logic [width-1:0] acc_q, acc_base, acc_nx;
    logic [cwid-1:0]  cnt_q, cnt_base, cnt_nx;
    logic             dup_q, dup_base, dup_nx;
    logic             err_q, err_base, err_nx;

    logic             out_valid_q;
    logic [width-1:0] z_q;
    logic [cwid-1:0]  z_cnt_q;
    logic             z_dup_q, z_err_q;

    logic [width-1:0] dec;
    logic             range_err;
    logic             accept;

    decode_stream_decode #(
        .width(width)
    ) u_decode (
        .A(A),
        .Z(dec)
    );

`ifdef DECODE_STREAM_RANGE_CHECK_EN
    localparam logic [m:0] width_c = (m + 1)'(width);
    assign range_err = ({1'b0, A} >= width_c);
`else
    assign range_err = 1'b0;
`endif

    // Output slot frees up when empty or being drained this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        // In IDLE the accumulator is empty by construction; start from zero.
        if (state_q == ACCUM) begin
            acc_base = acc_q;
            cnt_base = cnt_q;
            dup_base = dup_q;
            err_base = err_q;
        end else begin
            acc_base = '0;
            cnt_base = '0;
            dup_base = 1'b0;
            err_base = 1'b0;
        end
        acc_nx = acc_base | dec;
        cnt_nx = (cnt_base == cnt_max) ? cnt_base : cnt_base + 1'b1;
        dup_nx = dup_base | (|(acc_base & dec));
        err_nx = err_base | range_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            dup_q       <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            z_q         <= '0;
            z_cnt_q     <= '0;
            z_dup_q     <= 1'b0;
            z_err_q     <= 1'b0;
        end else begin
            if (accept && in_last) begin
                z_q         <= acc_nx;
                z_cnt_q     <= cnt_nx;
                z_dup_q     <= dup_nx;
                z_err_q     <= err_nx;
                out_valid_q <= 1'b1;
                acc_q       <= '0;
                cnt_q       <= '0;
                dup_q       <= 1'b0;
                err_q       <= 1'b0;
                state_q     <= IDLE;
            end else begin
                if (accept) begin
                    acc_q   <= acc_nx;
                    cnt_q   <= cnt_nx;
                    dup_q   <= dup_nx;
                    err_q   <= err_nx;
                    state_q <= ACCUM;
                end
                if (out_ready) begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign Z         = z_q;
    assign Z_cnt     = z_cnt_q;
    assign Z_dup     = z_dup_q;
    assign Z_err     = z_err_q;

endmodule

// File: tb/tb_decode_stream.sv
module tb_decode_stream;

`ifdef DECODE_STREAM_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_last, out_valid, out_ready;
    logic [2:0] a_s;
    logic [7:0] z;
    logic [3:0] z_cnt;
    logic       z_dup, z_err;

    // Second instance with a non power-of-two width for out-of-range beats.
    logic       v6, rdy6, l6, val6, r6;
    logic [2:0] a6;
    logic [5:0] z6;
    logic [3:0] cnt6;
    logic       dup6, err6;

    always #5 clk = ~clk;

    decode_stream #(.width(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(a_s),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .Z(z),
        .Z_cnt(z_cnt), .Z_dup(z_dup), .Z_err(z_err)
    );

    decode_stream #(.width(6)) u_dut6 (
        .clk(clk), .rst(rst), .in_valid(v6), .in_ready(rdy6), .A(a6),
        .in_last(l6), .out_valid(val6), .out_ready(r6), .Z(z6),
        .Z_cnt(cnt6), .Z_dup(dup6), .Z_err(err6)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the burst is a list of indices; the result is computed from it.
    int         beats[$];
    logic       m_valid = 1'b0;
    logic [7:0] m_z     = '0;
    logic [3:0] m_cnt   = '0;
    logic       m_dup   = 1'b0;
    logic       m_err   = 1'b0;

    task automatic model_finish();
        int seen[8];
        foreach (seen[k]) seen[k] = 0;
        m_z   = '0;
        m_dup = 1'b0;
        m_err = 1'b0;
        foreach (beats[k]) begin
            if (beats[k] < 8) begin
                m_z[beats[k]] = 1'b1;
                seen[beats[k]]++;
                if (seen[beats[k]] > 1) m_dup = 1'b1;
            end else begin
                m_err = RC;
            end
        end
        m_cnt = (beats.size() > 15) ? 4'd15 : 4'(beats.size());
        beats.delete();
        m_valid = 1'b1;
    endtask

    task automatic tick(input logic v, input logic [2:0] a, input logic l, input logic r,
                        input logic rs, output logic rdy_seen);
        logic acc;
        in_valid  = v;
        a_s       = a;
        in_last   = l;
        out_ready = r;
        rst       = rs;
        #1;
        rdy_seen = in_ready;
        chk("in_ready", in_ready, !m_valid || r);
        acc = v && (!m_valid || r);
        @(posedge clk);
        if (rs) begin
            beats.delete();
            m_valid = 1'b0;
            m_z     = '0;
            m_cnt   = '0;
            m_dup   = 1'b0;
            m_err   = 1'b0;
        end else begin
            if (acc) beats.push_back(int'(a));
            if (acc && l) model_finish();
            else if (r) m_valid = 1'b0;
        end
        #1;
        chk("out_valid", out_valid, m_valid);
        if (m_valid || rs) begin
            chk("Z", z, m_z);
            chk("Z_cnt", z_cnt, m_cnt);
            chk("Z_dup", z_dup, m_dup);
            chk("Z_err", z_err, m_err);
        end
    endtask

    typedef struct {
        logic       v;
        logic [2:0] a;
        logic       l;
        logic       r;
        logic       rs;
        logic       e_rdy;
        logic       e_valid;
        logic       chk_d;
        logic [7:0] e_z;
        logic [3:0] e_cnt;
        logic       e_dup;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic rdy;
        // v a l r rs | rdy valid chk_d z cnt dup
        tbl[0]  = '{1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h20, 4'd1, 1'b0};
        tbl[1]  = '{1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0};
        tbl[2]  = '{1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0};
        tbl[3]  = '{1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0};
        tbl[4]  = '{1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h0A, 4'd3, 1'b1};
        for (int i = 5; i < 10; i++)
            tbl[i] = '{1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h0A, 4'd3, 1'b1};
        tbl[10] = '{1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 4'd1, 1'b0};
        tbl[11] = '{1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0};
        tbl[12] = '{1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 4'd0, 1'b0};
        tbl[13] = '{1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 4'd1, 1'b0};
        tbl[14] = '{1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0};

        v6 = 1'b0; a6 = '0; l6 = 1'b0; r6 = 1'b1;

        // Reset, then in_ready must be high even with out_ready low.
        tick(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, rdy);
        tick(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, rdy);
        rst       = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("in_ready_after_reset", in_ready, 1'b1);
        chk("dut6_reset_valid", val6, 1'b0);
        out_ready = 1'b1;

        // Width 6: index 7 is out of range; index 6 too.
        v6 = 1'b1; a6 = 3'd7; l6 = 1'b1; r6 = 1'b1;
        @(posedge clk); #1;
        chk("w6_oor_valid", val6, 1'b1);
        chk("w6_oor_z", z6, 6'h00);
        chk("w6_oor_cnt", cnt6, 4'd1);
        chk("w6_oor_dup", dup6, 1'b0);
        chk("w6_oor_err", err6, RC);
        a6 = 3'd5; l6 = 1'b0;
        @(posedge clk); #1;
        chk("w6_nonlast_valid", val6, 1'b0);
        a6 = 3'd6;
        @(posedge clk); #1;
        a6 = 3'd5; l6 = 1'b1;
        @(posedge clk); #1;
        chk("w6_burst_valid", val6, 1'b1);
        chk("w6_burst_z", z6, 6'h20);
        chk("w6_burst_cnt", cnt6, 4'd3);
        chk("w6_burst_dup", dup6, 1'b1);
        chk("w6_burst_err", err6, RC);
        v6 = 1'b0; l6 = 1'b0;

        // Directed table.
        foreach (tbl[i]) begin
            tick(tbl[i].v, tbl[i].a, tbl[i].l, tbl[i].r, tbl[i].rs, rdy);
            chk($sformatf("tbl%0d_rdy", i), rdy, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].e_valid);
            if (tbl[i].chk_d) begin
                chk($sformatf("tbl%0d_z", i), z, tbl[i].e_z);
                chk($sformatf("tbl%0d_cnt", i), z_cnt, tbl[i].e_cnt);
                chk($sformatf("tbl%0d_dup", i), z_dup, tbl[i].e_dup);
            end
        end

        // 20-beat burst: count saturates at 15.
        for (int i = 0; i < 20; i++) tick(1'b1, 3'(i % 8), i == 19, 1'b1, 1'b0, rdy);
        chk("sat_valid", out_valid, 1'b1);
        chk("sat_z", z, 8'hFF);
        chk("sat_cnt", z_cnt, 4'd15);
        chk("sat_dup", z_dup, 1'b1);
        tick(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, rdy);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                 $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 199) == 0, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
